// File: rtl/register_status_table.sv
// register_status_table
// Tomasulo register status table: one producer tag (Qi) and one committed
// value per architectural register. Dispatch claims destinations via the
// issue port and reads sources via two read ports; the CDB retires results.
// Optional feature macro: REG_STATUS_CDB_BYPASS_EN forwards a matching CDB
// broadcast straight onto the read ports in the same cycle.

module register_status_table #(
  parameter int                NUM_REGS   = 8,
  parameter int                DATA_W     = 16,
  parameter int                TAG_W      = 3,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(16'h0001),
  localparam int               IDX_W      = $clog2(NUM_REGS),
  localparam int               CNT_W      = $clog2(NUM_REGS) + 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Issue_en,
  input  logic [IDX_W-1:0]  Issue_reg,
  input  logic [TAG_W-1:0]  Issue_tag,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  input  logic              Flush,
  input  logic [IDX_W-1:0]  Rj_addr,
  input  logic [IDX_W-1:0]  Rk_addr,
  output logic [TAG_W-1:0]  Qj,
  output logic [TAG_W-1:0]  Qk,
  output logic [DATA_W-1:0] Vj,
  output logic [DATA_W-1:0] Vk,
  output logic [CNT_W-1:0]  Pending_count,
  output logic              Retire_pulse
);

  localparam logic [TAG_W-1:0] TAG_FREE = '0;

  logic [TAG_W-1:0]  tag_q  [NUM_REGS];
  logic [DATA_W-1:0] data_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_d  [NUM_REGS];
  logic [DATA_W-1:0] data_d [NUM_REGS];
  logic [CNT_W-1:0]  count_d;
  logic              retire_any;
  logic              cdb_live;
  logic              issue_live;

  assign cdb_live   = CDB_valid && (CDB_tag != TAG_FREE);
  assign issue_live = Issue_en && (Issue_tag != TAG_FREE);

  // Next-state: flush beats everything; otherwise CDB retire, then issue
  // so the newest producer of a register overrides a same-cycle retire.
  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    retire_any = 1'b0;
    count_d    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      tag_d[r]  = tag_q[r];
      data_d[r] = data_q[r];
    end

    if (Flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_d[r] = TAG_FREE;
      end
    end else begin
      if (cdb_live) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (tag_q[r] == CDB_tag) begin
            data_d[r]  = CDB_data;
            tag_d[r]   = TAG_FREE;
            retire_any = 1'b1;
          end
        end
      end
      if (issue_live) begin
        tag_d[Issue_reg] = Issue_tag;
      end
    end

    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + CNT_W'(tag_d[r] != TAG_FREE);
    end
  end

  // State registers: tags, committed values, pending count and retire flag.
  // NOTE: the data array is reset as well, because RESET_DATA is an
  // architecturally visible value and not just a don't-care power-up state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r]  <= TAG_FREE;
        data_q[r] <= RESET_DATA;
      end
      Pending_count <= '0;
      Retire_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values regardless of statement order.
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r]  <= tag_d[r];
        data_q[r] <= data_d[r];
      end
      Pending_count <= count_d;
      Retire_pulse  <= retire_any;
    end
  end

  // Operand read ports: stored state, optionally overridden by a live CDB hit.
  always_comb begin
    Qj = tag_q[Rj_addr];
    Vj = data_q[Rj_addr];
    Qk = tag_q[Rk_addr];
    Vk = data_q[Rk_addr];
`ifdef REG_STATUS_CDB_BYPASS_EN
    if (cdb_live && (tag_q[Rj_addr] == CDB_tag)) begin
      Qj = TAG_FREE;
      Vj = CDB_data;
    end
    if (cdb_live && (tag_q[Rk_addr] == CDB_tag)) begin
      Qk = TAG_FREE;
      Vk = CDB_data;
    end
`else
    // Without forwarding the retired value becomes visible after the edge.
`endif
  end

endmodule

// File: tb/tb_register_status_table.sv
// tb_register_status_table
// Scoreboard bench for register_status_table. The stimulus process drives one
// vector per cycle, predicts the outputs from an array-based model of the
// table and queues the prediction; a monitor on the falling edge pops and
// compares. Compile with REG_STATUS_CDB_BYPASS_EN to exercise forwarding.

module tb_register_status_table;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int TAG_W    = 3;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 4;
  localparam logic [DATA_W-1:0] RST_VAL = 16'h0001;

  logic              Clock;
  logic              Resetn;
  logic              Issue_en;
  logic [IDX_W-1:0]  Issue_reg;
  logic [TAG_W-1:0]  Issue_tag;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  logic              Flush;
  logic [IDX_W-1:0]  Rj_addr;
  logic [IDX_W-1:0]  Rk_addr;
  logic [TAG_W-1:0]  Qj;
  logic [TAG_W-1:0]  Qk;
  logic [DATA_W-1:0] Vj;
  logic [DATA_W-1:0] Vk;
  logic [CNT_W-1:0]  Pending_count;
  logic              Retire_pulse;

  register_status_table #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W),
    .RESET_DATA(RST_VAL)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Issue_en     (Issue_en),
    .Issue_reg    (Issue_reg),
    .Issue_tag    (Issue_tag),
    .CDB_valid    (CDB_valid),
    .CDB_tag      (CDB_tag),
    .CDB_data     (CDB_data),
    .Flush        (Flush),
    .Rj_addr      (Rj_addr),
    .Rk_addr      (Rk_addr),
    .Qj           (Qj),
    .Qk           (Qk),
    .Vj           (Vj),
    .Vk           (Vk),
    .Pending_count(Pending_count),
    .Retire_pulse (Retire_pulse)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int qj;
    int vj;
    int qk;
    int vk;
    int cnt;
    int ret;
  } expect_t;

  expect_t exp_q[$];
  int      n_vectors = 0;
  int      n_err     = 0;

  // Reference model: plain arrays of producer tags and committed values.
  int tag_m  [NUM_REGS];
  int data_m [NUM_REGS];
  int retire_m;

  task automatic check(input string name, input int act, input int exp);
    n_vectors++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      tag_m[r]  = 0;
      data_m[r] = int'(RST_VAL);
    end
    retire_m = 0;
  endtask

  function automatic int pending_m();
    int n = 0;
    foreach (tag_m[r]) if (tag_m[r] != 0) n++;
    return n;
  endfunction

  // What a read port should show given the current model and CDB inputs.
  task automatic read_m(input int addr, input int cv, input int ctag,
                        input int cdata, output int q, output int v);
    q = tag_m[addr];
    v = data_m[addr];
`ifdef REG_STATUS_CDB_BYPASS_EN
    if (cv != 0 && ctag != 0 && tag_m[addr] == ctag) begin
      q = 0;
      v = cdata;
    end
`endif
  endtask

  // Clock-edge rules: flush wins; else every register waiting on the
  // broadcast tag takes the data, then a live issue claims its register.
  task automatic model_step(input int en, input int ireg, input int itag,
                            input int cv, input int ctag, input int cdata,
                            input int fl);
    retire_m = 0;
    if (fl != 0) begin
      foreach (tag_m[r]) tag_m[r] = 0;
    end else begin
      if (cv != 0 && ctag != 0) begin
        foreach (tag_m[r]) begin
          if (tag_m[r] == ctag) begin
            data_m[r] = cdata;
            tag_m[r]  = 0;
            retire_m  = 1;
          end
        end
      end
      if (en != 0 && itag != 0) tag_m[ireg] = itag;
    end
  endtask

  // One cycle of stimulus: drive, predict, queue, then advance the model.
  task automatic apply(input int en, input int ireg, input int itag,
                       input int cv, input int ctag, input int cdata,
                       input int fl, input int rj, input int rk, input int rst);
    expect_t e;
    Issue_en  = (en != 0);
    Issue_reg = IDX_W'(ireg);
    Issue_tag = TAG_W'(itag);
    CDB_valid = (cv != 0);
    CDB_tag   = TAG_W'(ctag);
    CDB_data  = DATA_W'(cdata);
    Flush     = (fl != 0);
    Rj_addr   = IDX_W'(rj);
    Rk_addr   = IDX_W'(rk);
    Resetn    = (rst != 0);
    if (rst == 0) model_reset();
    read_m(rj, cv, ctag, cdata, e.qj, e.vj);
    read_m(rk, cv, ctag, cdata, e.qk, e.vk);
    e.cnt = pending_m();
    e.ret = retire_m;
    exp_q.push_back(e);
    @(posedge Clock);
    if (rst != 0) model_step(en, ireg, itag, cv, ctag, cdata, fl);
    #1;
  endtask

  // Monitor: every falling edge with a queued prediction is compared.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      expect_t e;
      e = exp_q.pop_front();
      check("Qj", int'(Qj), e.qj);
      check("Vj", int'(Vj), e.vj);
      check("Qk", int'(Qk), e.qk);
      check("Vk", int'(Vk), e.vk);
      check("Pending_count", int'(Pending_count), e.cnt);
      check("Retire_pulse", int'(Retire_pulse), e.ret);
    end
  end

  initial begin
    Resetn    = 1'b0;
    Issue_en  = 1'b0;
    Issue_reg = '0;
    Issue_tag = '0;
    CDB_valid = 1'b0;
    CDB_tag   = '0;
    CDB_data  = '0;
    Flush     = 1'b0;
    Rj_addr   = '0;
    Rk_addr   = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;

    // Reset state and release.
    apply(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 3, 5, 1);

    // Single issue then retire of R3.
    apply(1, 3, 2, 0, 0, 0, 0, 3, 3, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    apply(0, 0, 0, 1, 2, 'h00AB, 0, 3, 3, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 3, 3, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 3, 1, 1);

    // Two registers waiting on the same station retire together.
    apply(1, 1, 1, 0, 0, 0, 0, 1, 5, 1);
    apply(1, 5, 1, 0, 0, 0, 0, 1, 5, 1);
    apply(0, 0, 0, 1, 1, 'h1234, 0, 1, 5, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 5, 1);

    // WAW: older producer must not update R2.
    apply(1, 2, 1, 0, 0, 0, 0, 2, 2, 1);
    apply(1, 2, 3, 0, 0, 0, 0, 2, 2, 1);
    apply(0, 0, 0, 1, 1, 'h0055, 0, 2, 2, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 2, 2, 1);
    // Same-cycle issue and retire on R4: new tag kept, data taken.
    apply(1, 4, 1, 0, 0, 0, 0, 4, 2, 1);
    apply(1, 4, 2, 1, 1, 'h0077, 0, 4, 4, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 4, 2, 1);

    // Issue with tag 0 and a CDB with tag 0 change nothing.
    apply(1, 6, 0, 1, 0, 'hBEEF, 0, 6, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 6, 0, 1);

    // Flush with three pending tags and a matching broadcast.
    apply(1, 0, 5, 0, 0, 0, 0, 0, 2, 1);
    apply(0, 0, 0, 1, 3, 'hDEAD, 1, 2, 4, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 2, 4, 1);

    // Forwarding window: R6 waits on station 4, broadcast read on k.
    apply(1, 6, 4, 0, 0, 0, 0, 0, 6, 1);
    apply(0, 0, 0, 1, 4, 'h0F0F, 0, 6, 6, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 6, 6, 1);

    // Reset asserted in the middle of an issue.
    apply(1, 7, 6, 0, 0, 0, 0, 7, 6, 1);
    apply(1, 1, 7, 0, 0, 0, 0, 7, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 7, 1, 1);

    // Randomised traffic with broadcasts biased toward pending tags.
    for (int i = 0; i < 400; i++) begin
      int en, ireg, itag, cv, ctag, cdata, fl, rj, rk, rst;
      en    = ($urandom_range(0, 9) < 6) ? 1 : 0;
      ireg  = $urandom_range(0, NUM_REGS - 1);
      itag  = $urandom_range(0, (1 << TAG_W) - 1);
      cv    = ($urandom_range(0, 9) < 5) ? 1 : 0;
      ctag  = ($urandom_range(0, 1) == 1) ? tag_m[$urandom_range(0, NUM_REGS - 1)]
                                          : $urandom_range(0, (1 << TAG_W) - 1);
      cdata = $urandom_range(0, 16'hFFFF);
      fl    = ($urandom_range(0, 29) == 0) ? 1 : 0;
      rj    = $urandom_range(0, NUM_REGS - 1);
      rk    = $urandom_range(0, NUM_REGS - 1);
      rst   = ($urandom_range(0, 149) == 0) ? 0 : 1;
      apply(en, ireg, itag, cv, ctag, cdata, fl, rj, rk, rst);
    end

    Issue_en  = 1'b0;
    CDB_valid = 1'b0;
    Flush     = 1'b0;
    repeat (3) @(negedge Clock);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_err);
    $finish;
  end

endmodule

// File: doc/register_status_table.md
Name: register_status_table

Overview:
- Parametrised Tomasulo register status table, successor to the fixed 4-register/2-station version.
- For each architectural register, holds the tag (Qi) of the reservation station that will produce its value, plus the committed value.
- Sits between the dispatch unit, which issues tags and reads operands, and the CDB, which broadcasts results.
- Provides two operand read ports with optional same-cycle CDB forwarding.

Parameters:
- NUM_REGS, 8, number of architectural registers (power of 2, >=2).
- DATA_W, 16, register data width.
- TAG_W, 3, station tag width; tag 0 = FREE, 1..2^TAG_W-1 = reservation stations.
- RESET_DATA, 16'h0001, value loaded into every register on reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Issue_en  in  1  dispatch claims a destination register this cycle.
- Issue_reg  in  $clog2(NUM_REGS)  destination register index.
- Issue_tag  in  TAG_W  producing station tag.
- CDB_valid  in  1  CDB broadcast valid.
- CDB_tag  in  TAG_W  broadcasting station tag.
- CDB_data  in  DATA_W  broadcast result.
- Flush  in  1  synchronous clear of all pending tags (mispredict/recovery).
- Rj_addr, Rk_addr  in  $clog2(NUM_REGS)  operand read indices.
- Qj, Qk  out  TAG_W  pending tag of operand (0 = value ready).
- Vj, Vk  out  DATA_W  operand value (valid when Q = 0).
- Pending_count  out  $clog2(NUM_REGS)+1  number of registers with nonzero tag.
- Retire_pulse  out  1  registered; high one cycle after a CDB broadcast retired >=1 register.

Behaviour:
- Reset (Resetn low, asynchronous): all tags = 0, all data = RESET_DATA, Pending_count = 0, Retire_pulse = 0. Takes effect immediately mid-operation, and any in-flight issue is lost.
- Each rising edge, in priority order:
  1. Flush = 1: all tags cleared to 0, data untouched, Issue/CDB ignored that cycle, Pending_count = 0 next cycle.
  2. CDB retire: for each register r with tag[r] == CDB_tag and CDB_valid and CDB_tag != 0: data[r] <= CDB_data, tag[r] <= 0. Multiple registers may retire in the same cycle.
  3. Issue: if Issue_en and Issue_tag != 0: tag[Issue_reg] <= Issue_tag. This overrides step 2's tag clear for the same register (WAW: newest producer wins), but data[Issue_reg] still takes CDB_data if it matched.
- Issue_tag == 0 with Issue_en: ignored, no state change.
- CDB_tag == 0 or tag mismatch: no register change.
- Register whose tag was overwritten by a later issue is NOT updated by the older station's broadcast.
- Pending_count: registered, equals the population count of nonzero tags after the edge's update.
- Retire_pulse <= 1 iff step 2 cleared at least one tag and Flush = 0.
- Read ports are combinational from current state: Qj = tag[Rj_addr], Vj = data[Rj_addr], same for k. Forwarding is governed by the optional feature.
- Issue and read of the same register in one cycle: read returns the pre-issue state (dispatch must read sources before claiming the destination).

Optional Feature:
- Macro REG_STATUS_CDB_BYPASS_EN.
- Defined: if CDB_valid and CDB_tag != 0 and tag[Rj_addr] == CDB_tag, then Qj = 0 and Vj = CDB_data in the same cycle; likewise for k.
- Undefined: read ports reflect stored state only, and forwarded values appear one cycle later.

Test Plan:
- Reset -> all Q = 0, V = 16'h0001, Pending_count = 0; assert Resetn low mid-issue -> state returns to reset values immediately.
- Issue R3 tag 2, next cycle read R3 -> Qj = 2, Pending_count = 1; CDB tag 2 data 16'h00AB -> next cycle Qj = 0, Vj = 16'h00AB, Retire_pulse = 1 for one cycle, Pending_count = 0.
- Issue R1 tag 1 and R5 tag 1 (two cycles), CDB tag 1 data 16'h1234 -> both R1 and R5 = 16'h1234, tags 0, count 2 -> 0.
- WAW: R2 tag 1, then R2 tag 3, CDB tag 1 data 16'h0055 -> R2 tag stays 3, data unchanged; same-cycle Issue R4 tag 2 with CDB tag 1 on R4 (tag 1) -> R4 tag = 2, data = CDB_data.
- Flush with 3 pending tags and a simultaneous CDB -> all tags 0, data unchanged, Retire_pulse = 0.
- With REG_STATUS_CDB_BYPASS_EN, R6 tag 4 and CDB tag 4 data 16'h0F0F in the same cycle with Rk_addr = 6 -> Qk = 0, Vk = 16'h0F0F combinationally. Without the macro -> Qk = 4 that cycle.
